// File: rtl/time_ascii_sender.sv
// time_ascii_sender: snapshots the hour/min/sec/centisecond time bus on a start
// pulse and streams it as ASCII "HH:MM:SS.CC" (optionally followed by CR LF)
// to a UART transmitter, one byte per tx_start/tx_busy handshake.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for start; snapshot taken on the accepting edge
// S_LOAD     | convert snapshot to saturated two-digit ASCII per field
// S_SEND     | wait for UART idle, then issue tx_start with char[idx]
// S_WAIT_ACK | wait for tx_busy to rise; timer expiry counts the byte as sent
// S_WAIT_TX  | wait for tx_busy to fall, then advance to next char
// S_FIN      | done pulse, busy dropped, back to idle
module time_ascii_sender #(
   parameter bit SEND_CRLF   = 1'b1,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [4:0] hour,
   input  logic [6:0] min,
   input  logic [6:0] sec,
   input  logic [6:0] msec,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       done
);

   localparam int         TW       = $clog2(ACK_TIMEOUT + 1);
   localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd12 : 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT_ACK,
      S_WAIT_TX,
      S_FIN
   } state_t;

   state_t          state, state_n;
   logic [4:0]      hour_q;
   logic [6:0]      min_q, sec_q, msec_q;
   logic [7:0]      dig_q [8];
   logic [3:0]      idx;
   logic [TW-1:0]   tmr;
   logic            issue;
   logic            adv;
   logic [7:0]      char_sel;

   // Two ASCII digits of a field; anything above 99 reads as "99".
   function automatic logic [15:0] to_ascii2(input logic [6:0] v);
      logic [6:0] s, t, o;
      s = (v > 7'd99) ? 7'd99 : v;
      t = s / 7'd10;
      o = s % 7'd10;
      return {8'h30 + {1'b0, t}, 8'h30 + {1'b0, o}};
   endfunction

   // Frame byte selected by the character index.
   always_comb begin
      char_sel = 8'h00;
      case (idx)
         4'd0:    char_sel = dig_q[0];
         4'd1:    char_sel = dig_q[1];
         4'd2:    char_sel = 8'h3A;
         4'd3:    char_sel = dig_q[2];
         4'd4:    char_sel = dig_q[3];
         4'd5:    char_sel = 8'h3A;
         4'd6:    char_sel = dig_q[4];
         4'd7:    char_sel = dig_q[5];
         4'd8:    char_sel = 8'h2E;
         4'd9:    char_sel = dig_q[6];
         4'd10:   char_sel = dig_q[7];
         4'd11:   char_sel = 8'h0D;
         4'd12:   char_sel = 8'h0A;
         default: char_sel = 8'h00;
      endcase
   end

   // Next-state logic plus the issue/advance strobes for the datapath.
   always_comb begin
      state_n = state;
      issue   = 1'b0;
      adv     = 1'b0;
      case (state)
         S_IDLE:     if (start) state_n = S_LOAD;
         S_LOAD:     state_n = S_SEND;
         S_SEND: begin
            if (!tx_busy) begin
               issue   = 1'b1;
               state_n = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (tx_busy)         state_n = S_WAIT_TX;
            else if (tmr == '0)  adv = 1'b1;
         end
         S_WAIT_TX:  if (!tx_busy) adv = 1'b1;
         S_FIN:      state_n = S_IDLE;
         default:    state_n = S_IDLE;
      endcase
      if (adv) state_n = (idx == LAST_IDX) ? S_FIN : S_SEND;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Snapshot, digit conversion, index/timer and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hour_q   <= '0;
         min_q    <= '0;
         sec_q    <= '0;
         msec_q   <= '0;
         for (int i = 0; i < 8; i++) dig_q[i] <= 8'h30;
         idx      <= '0;
         tmr      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (state == S_IDLE && start) begin
            hour_q <= hour;
            min_q  <= min;
            sec_q  <= sec;
            msec_q <= msec;
         end
         if (state == S_LOAD) begin
            {dig_q[0], dig_q[1]} <= to_ascii2({2'b00, hour_q});
            {dig_q[2], dig_q[3]} <= to_ascii2(min_q);
            {dig_q[4], dig_q[5]} <= to_ascii2(sec_q);
            {dig_q[6], dig_q[7]} <= to_ascii2(msec_q);
         end
         if (issue)
            tmr <= TW'(ACK_TIMEOUT - 1);
         else if (state == S_WAIT_ACK && tmr != '0)
            tmr <= tmr - TW'(1);
         if (state_n == S_FIN) idx <= '0;
         else if (adv)         idx <= idx + 4'd1;
         tx_start <= issue;
         if (issue) tx_data <= char_sel;
         busy <= !(state_n == S_IDLE || state_n == S_FIN);
         done <= (state_n == S_FIN);
      end
   end

endmodule

// File: tb/tb_time_ascii_sender.sv
// Bench for time_ascii_sender: two instances (with and without CR LF), a frame
// model built from plain arithmetic on the snapshot, a per-cycle output
// checker, and literal frames that pin the model for the directed cases.
module tb_time_ascii_sender;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start [2];
   logic [4:0] hour = '0;
   logic [6:0] min = '0, sec = '0, msec = '0;
   logic       tx_busy [2];
   logic       ts [2];
   logic [7:0] td [2];
   logic       bsy [2];
   logic       dn [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   time_ascii_sender #(.SEND_CRLF(1'b1), .ACK_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start[0]), .hour(hour), .min(min), .sec(sec),
      .msec(msec), .tx_busy(tx_busy[0]), .tx_start(ts[0]), .tx_data(td[0]),
      .busy(bsy[0]), .done(dn[0]));

   time_ascii_sender #(.SEND_CRLF(1'b0), .ACK_TIMEOUT(16)) dut_nocrlf (
      .clk(clk), .rst(rst), .start(start[1]), .hour(hour), .min(min), .sec(sec),
      .msec(msec), .tx_busy(tx_busy[1]), .tx_start(ts[1]), .tx_data(td[1]),
      .busy(bsy[1]), .done(dn[1]));

   // UART stand-in for the CR LF instance: busy for 5 cycles after each
   // tx_start when enabled; the other instance never sees tx_busy.
   logic uart_en = 1'b1;
   int   uart_cnt;
   always @(posedge clk or posedge rst) begin
      if (rst)                   uart_cnt <= 0;
      else if (uart_en && ts[0]) uart_cnt <= 5;
      else if (uart_cnt > 0)     uart_cnt <= uart_cnt - 1;
   end
   assign tx_busy[0] = (uart_cnt > 0);
   assign tx_busy[1] = 1'b0;

   // ---------------- model ----------------
   logic [7:0] expq [2][$];
   logic [7:0] logq [2][$];
   logic [7:0] pin  [2][$];
   bit         pin_on [2];
   bit         act [2];
   bit         fin_pend [2];
   logic [7:0] last_data [2];
   int         frames [2];
   int         nbytes [2];
   int         last_cyc [2];
   int         cyc = 0;

   function automatic void mk_frame(input int h, input int m, input int s,
                                    input int c, input bit crlf,
                                    output logic [7:0] f[$]);
      int v [4];
      int x;
      v = '{h, m, s, c};
      f = {};
      for (int i = 0; i < 4; i++) begin
         x = (v[i] > 99) ? 99 : v[i];
         f.push_back(8'(48 + x / 10));
         f.push_back(8'(48 + x % 10));
         if (i < 2)  f.push_back(8'h3A);
         if (i == 2) f.push_back(8'h2E);
      end
      if (crlf) begin
         f.push_back(8'h0D);
         f.push_back(8'h0A);
      end
   endfunction

   initial begin
      for (int d = 0; d < 2; d++) begin
         start[d] = 1'b0; act[d] = 0; fin_pend[d] = 0; last_data[d] = 8'h00;
         frames[d] = 0; nbytes[d] = 0; last_cyc[d] = 0; pin_on[d] = 0;
      end
   end

   // Model acceptance: a start is taken only while the model frame is idle.
   always @(posedge clk) begin
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (fin_pend[d]) begin
               act[d] = 0;
               fin_pend[d] = 0;
            end else if (start[d] && !act[d]) begin
               act[d] = 1;
               mk_frame(int'(hour), int'(min), int'(sec), int'(msec), (d == 0), expq[d]);
               logq[d] = {};
               nbytes[d] = 0;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            total++;
            if (ts[d] !== 1'b0 || bsy[d] !== 1'b0 || dn[d] !== 1'b0 || td[d] !== 8'h00) begin
               bad++;
               $display("FAIL reset_outputs[%0d]: got ts=%b busy=%b done=%b data=%h, want 0 0 0 00",
                        d, ts[d], bsy[d], dn[d], td[d]);
            end
            expq[d] = {}; act[d] = 0; fin_pend[d] = 0; last_data[d] = 8'h00;
         end else begin
            total++;
            if (ts[d] === 1'b1) begin
               if (expq[d].size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_byte[%0d]: got tx_start with %h, want no byte", d, td[d]);
               end else begin
                  if (td[d] !== expq[d][0]) begin
                     bad++;
                     $display("FAIL byte[%0d] #%0d: got %h, want %h", d, nbytes[d], td[d], expq[d][0]);
                  end
                  void'(expq[d].pop_front());
               end
               if (nbytes[d] > 0 && (d == 1 || !uart_en)) begin
                  total++;
                  if (cyc - last_cyc[d] < 16 || cyc - last_cyc[d] > 18) begin
                     bad++;
                     $display("FAIL ack_timeout_gap[%0d]: got %0d cycles, want 16..18", d, cyc - last_cyc[d]);
                  end
               end
               last_cyc[d] = cyc;
               logq[d].push_back(td[d]);
               last_data[d] = td[d];
               nbytes[d]++;
            end else if (td[d] !== last_data[d]) begin
               bad++;
               $display("FAIL data_hold[%0d]: got %h, want %h", d, td[d], last_data[d]);
            end

            total++;
            if (dn[d] === 1'b1) begin
               if (!act[d] || expq[d].size() != 0 || bsy[d] !== 1'b0) begin
                  bad++;
                  $display("FAIL done[%0d]: got done with active=%0d left=%0d busy=%b, want active=1 left=0 busy=0",
                           d, act[d], expq[d].size(), bsy[d]);
               end
               frames[d]++;
               fin_pend[d] = 1;
               if (pin_on[d]) begin
                  int bad_i;
                  bad_i = -1;
                  for (int i = 0; i < pin[d].size(); i++)
                     if (i >= logq[d].size() || logq[d][i] !== pin[d][i]) begin
                        if (bad_i < 0) bad_i = i;
                     end
                  total++;
                  if (bad_i >= 0 || logq[d].size() != pin[d].size()) begin
                     bad++;
                     $display("FAIL pinned_frame[%0d]: got %0d bytes (first diff at %0d), want %0d bytes",
                              d, logq[d].size(), bad_i, pin[d].size());
                  end
                  pin_on[d] = 0;
               end
            end else if (bsy[d] !== act[d]) begin
               bad++;
               $display("FAIL busy[%0d]: got %b, want %b", d, bsy[d], act[d]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_start(input int d);
      start[d] = 1'b1;
      step(1);
      start[d] = 1'b0;
   endtask

   task automatic set_time(input int h, input int m, input int s, input int c);
      hour = 5'(h); min = 7'(m); sec = 7'(s); msec = 7'(c);
   endtask

   task automatic wait_frames(input int d, input int target, input int budget);
      int k;
      k = 0;
      while (frames[d] < target && k < budget) begin
         step(1);
         k++;
      end
      total++;
      if (frames[d] < target) begin
         bad++;
         $display("FAIL frame_timeout[%0d]: got %0d frames, want %0d", d, frames[d], target);
      end
   endtask

   task automatic wait_bytes(input int d, input int n, input int budget);
      int k;
      k = 0;
      while (nbytes[d] < n && k < budget) begin
         step(1);
         k++;
      end
      total++;
      if (nbytes[d] < n) begin
         bad++;
         $display("FAIL byte_timeout[%0d]: got %0d bytes, want %0d", d, nbytes[d], n);
      end
   endtask

   initial begin
      int f0;
      logic [7:0] p1 [$];
      p1 = '{8'h30, 8'h31, 8'h3A, 8'h32, 8'h33, 8'h3A, 8'h34, 8'h35, 8'h2E, 8'h36, 8'h37, 8'h0D, 8'h0A};

      step(3);
      rst = 1'b0;
      step(2);

      // 01:23:45.67 with a responsive UART.
      set_time(1, 23, 45, 67);
      pin[0] = p1; pin_on[0] = 1;
      pulse_start(0);
      wait_frames(0, 1, 400);
      step(3);

      // All zero, no CR LF, UART never answers.
      set_time(0, 0, 0, 0);
      pin[1] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h30};
      pin_on[1] = 1;
      pulse_start(1);
      wait_frames(1, 1, 400);
      step(3);

      // Saturation and wide hour value.
      set_time(31, 127, 100, 5);
      pin[0] = '{8'h33, 8'h31, 8'h3A, 8'h39, 8'h39, 8'h3A, 8'h39, 8'h39, 8'h2E, 8'h30, 8'h35, 8'h0D, 8'h0A};
      pin_on[0] = 1;
      pulse_start(0);
      wait_frames(0, 2, 400);
      step(3);

      // Input change and second start mid-frame must not disturb anything.
      set_time(12, 34, 56, 78);
      pin[0] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h2E, 8'h37, 8'h38, 8'h0D, 8'h0A};
      pin_on[0] = 1;
      f0 = frames[0];
      pulse_start(0);
      wait_bytes(0, 3, 200);
      set_time(9, 9, 9, 9);
      pulse_start(0);
      wait_frames(0, f0 + 1, 400);
      step(60);
      total++;
      if (frames[0] != f0 + 1) begin
         bad++;
         $display("FAIL no_second_frame: got %0d frames, want %0d", frames[0] - f0, 1);
      end

      // Timeout path on the CR LF instance.
      uart_en = 1'b0;
      set_time(2, 3, 4, 5);
      pin[0] = '{8'h30, 8'h32, 8'h3A, 8'h30, 8'h33, 8'h3A, 8'h30, 8'h34, 8'h2E, 8'h30, 8'h35, 8'h0D, 8'h0A};
      pin_on[0] = 1;
      pulse_start(0);
      wait_frames(0, f0 + 2, 600);
      step(3);

      // Reset in the middle of byte 5, then a fresh complete frame.
      uart_en = 1'b1;
      set_time(1, 23, 45, 67);
      f0 = frames[0];
      pulse_start(0);
      wait_bytes(0, 5, 200);
      rst = 1'b1;
      pin_on[0] = 0;
      step(2);
      rst = 1'b0;
      step(2);
      total++;
      if (frames[0] != f0) begin
         bad++;
         $display("FAIL reset_abandon: got %0d frames, want %0d", frames[0], f0);
      end
      pin[0] = p1; pin_on[0] = 1;
      pulse_start(0);
      wait_frames(0, f0 + 1, 400);
      step(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
